pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised stall and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It generalises operand count per stage and adds an EX-stage forwarding path. It also owns the multiply/divide busy timer instead of taking busy from the MD unit. An optional stall-statistics block can be compiled in. It sits beside the datapath and drives the PC, IF/ID and ID/EX control; all forwarding muxes are combinational.

## Interface
Parameters:
- NUM_ID_SRC, 2: ID-stage source operands (branch compare, jr).
- NUM_EX_SRC, 2: EX-stage source operands (ALU/MD inputs).
- MUL_LAT, 5: MD busy cycles after a multiply start; must be ≥1.
- DIV_LAT, 10: MD busy cycles after a divide start; must be ≥1.
- CNT_W, 4: MD busy counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_src_addr  in  NUM_ID_SRC*5  ID source register numbers.
- id_src_tuse  in  NUM_ID_SRC*2  cycles until each ID source is consumed.
- id_src_data  in  NUM_ID_SRC*32  register-file read data.
- id_md  in  1  ID instruction uses the MD unit (mult/div/mfhi/mflo/mthi/mtlo).
- ex_src_addr, ex_src_data  in  NUM_EX_SRC*5, NUM_EX_SRC*32  EX source operands.
- ex_a3, ex_tnew, ex_wd  in  5, 2, 32  EX destination register, remaining latency, result.
- ex_md_start, ex_md_op  in  1, 1  MD start pulse; op 0 = multiply, 1 = divide.
- mem_src_addr, mem_src_data  in  5, 32  store-data operand.
- mem_a3, mem_tnew, mem_wd  in  5, 2, 32  MEM destination register, remaining latency, result.
- wb_a3, wb_wd  in  5, 32  WB destination register and write data.
- stat_clr  in  1  synchronous clear of the statistics counters.
- id_src_fwd, ex_src_fwd, mem_src_fwd  out  matching widths  forwarded operands.
- pc_en, if_id_en, id_ex_flush  out  1  pipeline control.
- md_busy  out  1  registered MD busy.
- stall_cnt, md_stall_cnt  out  32  statistics; present only with the macro.

## Operation
- Destination register 0 never matches. Any source with address 0 forwards the value 0.
- Hazard stall on ID source s when addr_s ≠ 0 and either:
  - addr_s == ex_a3 and tuse_s < ex_tnew, or
  - addr_s == mem_a3 and tuse_s < mem_tnew.
- MD stall = id_md && (ex_md_start || md_busy).
- stall = OR of all hazard stalls and the MD stall. Then pc_en = if_id_en = !stall and id_ex_flush = stall.
- ID forwarding priority: EX (only when ex_tnew == 0) > MEM > WB > id_src_data.
- EX forwarding priority: MEM > WB > ex_src_data.
- MEM forwarding: WB > mem_src_data.
- MD timer:
  - ex_md_start loads the counter with MUL_LAT or DIV_LAT according to ex_md_op.
  - Otherwise the counter decrements while nonzero.
  - md_busy = (counter ≠ 0).
  - A start while busy reloads the counter; the new operation supersedes the old one.

## Timing
- Reset: counter = 0, md_busy = 0, statistics = 0. Control outputs then follow the combinational equations: with no hazards, pc_en = 1, if_id_en = 1, id_ex_flush = 0.
- Forwarding and stall paths have zero latency (combinational). The timer and statistics counters update on the clk edge.
- If ex_md_start is high in cycle t, md_busy is high in cycles t+1 through t+LAT. id_md is stalled in cycles t through t+LAT and issues in cycle t+LAT+1.
- Reset asserted mid-operation clears the counter immediately (asynchronous); md_busy drops without waiting for a clock.
- When two stages match the same register, the youngest producer (highest priority) wins.

## Configuration
- HAZARD_STAT_EN defined:
  - stall_cnt increments on every cycle with stall = 1.
  - md_stall_cnt increments on cycles where the MD stall is the only stall cause.
  - Both counters saturate at 32'hFFFFFFFF.
  - stat_clr zeroes both counters and takes priority over increment.
- HAZARD_STAT_EN undefined: stall_cnt, md_stall_cnt and the stat_clr port are omitted, and no counter logic is synthesised.

## Structure
- Shared package holds:
  - Tuse/Tnew encodings (0–2).
  - The MD opcode constants MD_OP_MUL and MD_OP_DIV.
  - Default MUL_LAT and DIV_LAT.
- Sub-module md_busy_timer (parameters MUL_LAT, DIV_LAT, CNT_W) contains the counter and md_busy. Everything else stays in pipe_hazard_unit, using generate loops over the sources.

## Test plan
- lw $t0 in EX (ex_a3 = 8, ex_tnew = 2); ID beq reads $8 with tuse = 0 → stall = 1, pc_en = 0, id_ex_flush = 1. Next cycle with mem_tnew = 1 → still stalled. Then mem_tnew = 0 → release.
- lui in EX (ex_a3 = 9, ex_tnew = 0, ex_wd = 0x12340000); ID reads $9 → id_src_fwd = 0x12340000, no stall. Also mem_a3 = 9 with a different value → EX value still wins.
- Source address 0, with ex_a3 = mem_a3 = wb_a3 = 0 and nonzero write data → forwarded value is 0, no stall.
- ex_md_start with op = 1 at cycle 10, DIV_LAT = 10; id_md held high → stall in cycles 10–20, md_busy high in cycles 11–20, issue at cycle 21.
- Start a multiply, then assert reset mid-count → md_busy = 0 immediately. After deassertion, id_md is not stalled.
- With HAZARD_STAT_EN: 7 cycles of MD-only stall plus 3 cycles of hazard stall → stall_cnt = 10, md_stall_cnt = 7. Then stat_clr → both 0.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit: Tuse/Tnew stage counts,
// MD opcode constants and default multiply/divide latencies.
package pipe_hazard_unit_pkg;

    typedef enum logic [1:0] {
        TIME_0 = 2'd0,
        TIME_1 = 2'd1,
        TIME_2 = 2'd2
    } t_enc_e;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    // Register 0 is hardwired, so it never matches a producer.
    function automatic logic addr_hit(input reg_addr_t src, input reg_addr_t dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_md_busy_timer.sv
// Multiply/divide busy timer: loads the op latency on a start pulse and
// counts down; md_busy is high while the count is nonzero.
module md_busy_timer
    import pipe_hazard_unit_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_op,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_p1;
    logic [CNT_W-1:0] cnt_nxt;

    // A new start always supersedes whatever operation is still counting.
    always_comb begin
        cnt_nxt = cnt_p1;
        if (md_start) begin
            case (md_op)
                MD_OP_MUL: cnt_nxt = MUL_LOAD;
                MD_OP_DIV: cnt_nxt = DIV_LOAD;
                default:   cnt_nxt = MUL_LOAD;
            endcase
        end else if (cnt_p1 != '0) begin
            cnt_nxt = cnt_p1 - CNT_ONE;
        end
    end

    // stage p1: busy counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p1 <= '0;
        end else begin
            cnt_p1 <= cnt_nxt;
        end
    end

    assign md_busy = (cnt_p1 != '0);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Stall and forwarding controller for the 5-stage pipeline. Optional stall
// statistics are compiled in when HAZARD_STAT_EN is defined.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int NUM_ID_SRC = 2,
    parameter int NUM_EX_SRC = 2,
    parameter int MUL_LAT    = DEF_MUL_LAT,
    parameter int DIV_LAT    = DEF_DIV_LAT,
    parameter int CNT_W      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_ID_SRC*5-1:0]   id_src_addr,
    input  logic [NUM_ID_SRC*2-1:0]   id_src_tuse,
    input  logic [NUM_ID_SRC*32-1:0]  id_src_data,
    input  logic                      id_md,
    input  logic [NUM_EX_SRC*5-1:0]   ex_src_addr,
    input  logic [NUM_EX_SRC*32-1:0]  ex_src_data,
    input  logic [4:0]                ex_a3,
    input  logic [1:0]                ex_tnew,
    input  logic [31:0]               ex_wd,
    input  logic                      ex_md_start,
    input  logic                      ex_md_op,
    input  logic [4:0]                mem_src_addr,
    input  logic [31:0]               mem_src_data,
    input  logic [4:0]                mem_a3,
    input  logic [1:0]                mem_tnew,
    input  logic [31:0]               mem_wd,
    input  logic [4:0]                wb_a3,
    input  logic [31:0]               wb_wd,
`ifdef HAZARD_STAT_EN
    input  logic                      stat_clr,
`endif
    output logic [NUM_ID_SRC*32-1:0]  id_src_fwd,
    output logic [NUM_EX_SRC*32-1:0]  ex_src_fwd,
    output logic [31:0]               mem_src_fwd,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      id_ex_flush,
    output logic                      md_busy
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               md_stall_cnt
`endif
);

    logic [NUM_ID_SRC-1:0] id_haz;
    logic                  hazard_any;
    logic                  md_stall;
    logic                  stall;

    md_busy_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .md_start (ex_md_start),
        .md_op    (ex_md_op),
        .md_busy  (md_busy)
    );

    // EX results are only usable in ID once their remaining latency is zero.
    for (genvar i = 0; i < NUM_ID_SRC; i++) begin : g_id_src
        reg_addr_t   a;
        logic [1:0]  tuse;
        word_t       rf_data;
        word_t       fwd;

        assign a       = id_src_addr[i*5 +: 5];
        assign tuse    = id_src_tuse[i*2 +: 2];
        assign rf_data = id_src_data[i*32 +: 32];

        assign id_haz[i] = (addr_hit(a, ex_a3)  && (tuse < ex_tnew)) ||
                           (addr_hit(a, mem_a3) && (tuse < mem_tnew));

        always_comb begin
            fwd = rf_data;
            if (a == 5'd0) begin
                fwd = '0;
            end else if (addr_hit(a, ex_a3) && (ex_tnew == TIME_0)) begin
                fwd = ex_wd;
            end else if (addr_hit(a, mem_a3)) begin
                fwd = mem_wd;
            end else if (addr_hit(a, wb_a3)) begin
                fwd = wb_wd;
            end
        end

        assign id_src_fwd[i*32 +: 32] = fwd;
    end

    for (genvar j = 0; j < NUM_EX_SRC; j++) begin : g_ex_src
        reg_addr_t a;
        word_t     fwd;

        assign a = ex_src_addr[j*5 +: 5];

        always_comb begin
            fwd = ex_src_data[j*32 +: 32];
            if (a == 5'd0) begin
                fwd = '0;
            end else if (addr_hit(a, mem_a3)) begin
                fwd = mem_wd;
            end else if (addr_hit(a, wb_a3)) begin
                fwd = wb_wd;
            end
        end

        assign ex_src_fwd[j*32 +: 32] = fwd;
    end

    always_comb begin
        mem_src_fwd = mem_src_data;
        if (mem_src_addr == 5'd0) begin
            mem_src_fwd = '0;
        end else if (addr_hit(mem_src_addr, wb_a3)) begin
            mem_src_fwd = wb_wd;
        end
    end

    assign hazard_any  = |id_haz;
    assign md_stall    = id_md && (ex_md_start || md_busy);
    assign stall       = hazard_any || md_stall;
    assign pc_en       = !stall;
    assign if_id_en    = !stall;
    assign id_ex_flush = stall;

`ifdef HAZARD_STAT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // stage p1: statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (md_stall && !hazard_any) begin
                md_stall_cnt <= sat_inc(md_stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit; covers the statistics
// counters as well when HAZARD_STAT_EN is defined.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  id_src_addr;
    logic [3:0]  id_src_tuse;
    logic [63:0] id_src_data;
    logic        id_md;
    logic [9:0]  ex_src_addr;
    logic [63:0] ex_src_data;
    logic [4:0]  ex_a3;
    logic [1:0]  ex_tnew;
    logic [31:0] ex_wd;
    logic        ex_md_start;
    logic        ex_md_op;
    logic [4:0]  mem_src_addr;
    logic [31:0] mem_src_data;
    logic [4:0]  mem_a3;
    logic [1:0]  mem_tnew;
    logic [31:0] mem_wd;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic [63:0] id_src_fwd;
    logic [63:0] ex_src_fwd;
    logic [31:0] mem_src_fwd;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_flush;
    logic        md_busy;
`ifdef HAZARD_STAT_EN
    logic        stat_clr;
    logic [31:0] stall_cnt;
    logic [31:0] md_stall_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    pipe_hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_src_addr  (id_src_addr),
        .id_src_tuse  (id_src_tuse),
        .id_src_data  (id_src_data),
        .id_md        (id_md),
        .ex_src_addr  (ex_src_addr),
        .ex_src_data  (ex_src_data),
        .ex_a3        (ex_a3),
        .ex_tnew      (ex_tnew),
        .ex_wd        (ex_wd),
        .ex_md_start  (ex_md_start),
        .ex_md_op     (ex_md_op),
        .mem_src_addr (mem_src_addr),
        .mem_src_data (mem_src_data),
        .mem_a3       (mem_a3),
        .mem_tnew     (mem_tnew),
        .mem_wd       (mem_wd),
        .wb_a3        (wb_a3),
        .wb_wd        (wb_wd),
`ifdef HAZARD_STAT_EN
        .stat_clr     (stat_clr),
`endif
        .id_src_fwd   (id_src_fwd),
        .ex_src_fwd   (ex_src_fwd),
        .mem_src_fwd  (mem_src_fwd),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_flush  (id_ex_flush),
        .md_busy      (md_busy)
`ifdef HAZARD_STAT_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        id_src_addr  = '0;
        id_src_tuse  = '0;
        id_src_data  = '0;
        id_md        = 1'b0;
        ex_src_addr  = '0;
        ex_src_data  = '0;
        ex_a3        = '0;
        ex_tnew      = '0;
        ex_wd        = '0;
        ex_md_start  = 1'b0;
        ex_md_op     = 1'b0;
        mem_src_addr = '0;
        mem_src_data = '0;
        mem_a3       = '0;
        mem_tnew     = '0;
        mem_wd       = '0;
        wb_a3        = '0;
        wb_wd        = '0;
    endtask

    initial begin
        reset = 1'b1;
        clr_inputs();
`ifdef HAZARD_STAT_EN
        stat_clr = 1'b0;
`endif
        #3;
        chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
        chk("rst_if_id_en", {31'd0, if_id_en}, 32'd1);
        chk("rst_flush", {31'd0, id_ex_flush}, 32'd0);
`ifdef HAZARD_STAT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_md_stall_cnt", md_stall_cnt, 32'd0);
`endif
        tick();
        reset = 1'b0;
        tick();

        // load-use: lw $8 in EX, beq in ID reads $8 with tuse 0
        id_src_addr = {5'd0, 5'd8};
        ex_a3 = 5'd8; ex_tnew = 2'd2;
        #1;
        chk("lw_ex_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lw_ex_if_id_en", {31'd0, if_id_en}, 32'd0);
        chk("lw_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        tick();
        ex_a3 = 5'd0; ex_tnew = 2'd0;
        mem_a3 = 5'd8; mem_tnew = 2'd1; mem_wd = 32'hCAFE_0008;
        #1;
        chk("lw_mem_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        mem_tnew = 2'd0;
        #1;
        chk("lw_rel_pc_en", {31'd0, pc_en}, 32'd1);
        chk("lw_rel_flush", {31'd0, id_ex_flush}, 32'd0);
        chk("lw_rel_fwd", id_src_fwd[31:0], 32'hCAFE_0008);

        // tuse equal to tnew does not stall; EX value not ready so no forward
        mem_a3 = 5'd0;
        ex_a3 = 5'd8; ex_tnew = 2'd2; ex_wd = 32'hDEAD_BEEF;
        id_src_tuse = {2'd0, 2'd2};
        id_src_data = {32'h0, 32'h1111_0000};
        #1;
        chk("tuse_eq_pc_en", {31'd0, pc_en}, 32'd1);
        chk("tuse_eq_fwd", id_src_fwd[31:0], 32'h1111_0000);
        id_src_tuse = {2'd0, 2'd1};
        #1;
        chk("tuse_lt_pc_en", {31'd0, pc_en}, 32'd0);
        clr_inputs();

        // lui in EX forwards to ID lane 1 and beats MEM
        id_src_addr = {5'd9, 5'd0};
        id_src_data = {32'h2222_0000, 32'h3333_0000};
        ex_a3 = 5'd9; ex_tnew = 2'd0; ex_wd = 32'h1234_0000;
        mem_a3 = 5'd9; mem_wd = 32'hAAAA_0000;
        #1;
        chk("lui_ex_fwd", id_src_fwd[63:32], 32'h1234_0000);
        chk("lui_pc_en", {31'd0, pc_en}, 32'd1);
        chk("lane0_zero", id_src_fwd[31:0], 32'h0);
        ex_a3 = 5'd0;
        #1;
        chk("id_mem_fwd", id_src_fwd[63:32], 32'hAAAA_0000);
        mem_a3 = 5'd0; wb_a3 = 5'd9; wb_wd = 32'hBBBB_0000;
        #1;
        chk("id_wb_fwd", id_src_fwd[63:32], 32'hBBBB_0000);
        wb_a3 = 5'd0;
        #1;
        chk("id_rf_data", id_src_fwd[63:32], 32'h2222_0000);
        clr_inputs();

        // register 0 never forwards and never stalls
        ex_wd = 32'h1; mem_wd = 32'h2; wb_wd = 32'h3;
        ex_tnew = 2'd2; mem_tnew = 2'd2;
        id_src_data = {32'h44, 32'h45};
        ex_src_data = {32'h46, 32'h47};
        mem_src_data = 32'h48;
        #1;
        chk("zero_id0", id_src_fwd[31:0], 32'h0);
        chk("zero_id1", id_src_fwd[63:32], 32'h0);
        chk("zero_pc_en", {31'd0, pc_en}, 32'd1);
        chk("zero_ex0", ex_src_fwd[31:0], 32'h0);
        chk("zero_mem", mem_src_fwd, 32'h0);
        clr_inputs();

        // EX and MEM operand forwarding priority
        ex_src_addr = {5'd6, 5'd5};
        ex_src_data = {32'h66, 32'h55};
        mem_a3 = 5'd5; mem_wd = 32'hA5A5_0001;
        wb_a3 = 5'd5; wb_wd = 32'h5A5A_0002;
        #1;
        chk("ex_mem_fwd", ex_src_fwd[31:0], 32'hA5A5_0001);
        chk("ex_lane1_data", ex_src_fwd[63:32], 32'h66);
        mem_a3 = 5'd0;
        #1;
        chk("ex_wb_fwd", ex_src_fwd[31:0], 32'h5A5A_0002);
        wb_a3 = 5'd0;
        #1;
        chk("ex_data", ex_src_fwd[31:0], 32'h55);
        mem_src_addr = 5'd7; mem_src_data = 32'h77;
        mem_a3 = 5'd7; wb_a3 = 5'd7;
        #1;
        chk("mem_wb_fwd", mem_src_fwd, 32'h5A5A_0002);
        wb_a3 = 5'd0;
        #1;
        chk("mem_data", mem_src_fwd, 32'h77);
        clr_inputs();

        // divide: start cycle stalls, busy for 10 cycles, then issue
        id_md = 1'b1; ex_md_start = 1'b1; ex_md_op = 1'b1;
        #1;
        chk("div_start_pc_en", {31'd0, pc_en}, 32'd0);
        chk("div_start_busy", {31'd0, md_busy}, 32'd0);
        tick();
        ex_md_start = 1'b0;
        #1;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("div_busy_%0d", k), {31'd0, md_busy}, 32'd1);
            chk($sformatf("div_stall_%0d", k), {31'd0, pc_en}, 32'd0);
            tick();
        end
        chk("div_done_busy", {31'd0, md_busy}, 32'd0);
        chk("div_issue_pc_en", {31'd0, pc_en}, 32'd1);

        // multiply interrupted by asynchronous reset
        ex_md_start = 1'b1; ex_md_op = 1'b0;
        tick();
        ex_md_start = 1'b0;
        tick();
        chk("mul_busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("async_rst_pc_en", {31'd0, pc_en}, 32'd1);
        #1;
        reset = 1'b0;
        tick();
        chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("post_rst_pc_en", {31'd0, pc_en}, 32'd1);
        clr_inputs();

`ifdef HAZARD_STAT_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr0_stall", stall_cnt, 32'd0);
        chk("stat_clr0_md", md_stall_cnt, 32'd0);
        // two back-to-back multiply starts then 5 busy cycles: 7 MD-only stalls
        id_md = 1'b1; ex_md_start = 1'b1; ex_md_op = 1'b0;
        tick();
        tick();
        ex_md_start = 1'b0;
        repeat (5) tick();
        chk("stat_md_done_busy", {31'd0, md_busy}, 32'd0);
        id_md = 1'b0;
        id_src_addr = {5'd0, 5'd8};
        ex_a3 = 5'd8; ex_tnew = 2'd2;
        repeat (3) tick();
        clr_inputs();
        #1;
        chk("stat_stall_cnt", stall_cnt, 32'd10);
        chk("stat_md_stall_cnt", md_stall_cnt, 32'd7);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_stall", stall_cnt, 32'd0);
        chk("stat_clr_md", md_stall_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
